inst_decode_stage: RTL and testbench

Registered, queue-buffered instruction decode stage for the 32-bit five-field ISA (opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], ALUop[6:2], immed[16:0], target[26:0]).
- Accepts fetched instructions plus their PC over a valid/ready handshake into a DEPTH-entry FIFO.
- Presents the head entry fully decoded: instruction class, sign-extended immediate, zero-extended target, ALU op normalised per class, illegal-opcode flag.
- Sits between fetch and register-read; flush on branch/jump redirect.

---
 rtl/inst_decode_stage.sv | 137 +++++++++++++
 tb/tb_inst_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// rtl/inst_decode_stage.sv - queue-buffered instruction decode stage
// Holds fetched {inst, pc} pairs in order and presents the head entry decoded.
module inst_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       shamt,
  output logic [4:0]       aluop,
  output logic [XLEN-1:0]  imm_sext,
  output logic [XLEN-1:0]  target_zext,
  output logic [2:0]       itype,
  output logic             illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] IT_R   = 3'd0;
  localparam logic [2:0] IT_I   = 3'd1;
  localparam logic [2:0] IT_JI  = 3'd2;
  localparam logic [2:0] IT_JII = 3'd3;
  localparam logic [2:0] IT_ILL = 3'd4;

  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      inst_mem_d [DEPTH];
  logic [XLEN-1:0]  pc_mem_q   [DEPTH];
  logic [XLEN-1:0]  pc_mem_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        push;
  logic        pop;
  logic [31:0] head_inst;

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CNT_W'(DEPTH)) | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        inst_mem_d[tail_q] = inst;
        pc_mem_d[tail_q]   = pc_in;
        tail_d             = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; only pointers define what is valid.
  always_ff @(posedge clock) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  assign head_inst   = inst_mem_q[head_q];
  assign pc_out      = pc_mem_q[head_q];
  assign opcode      = head_inst[31:27];
  assign rd          = head_inst[26:22];
  assign rs          = head_inst[21:17];
  assign rt          = head_inst[16:12];
  assign shamt       = head_inst[11:7];
  assign imm_sext    = {{(XLEN-17){head_inst[16]}}, head_inst[16:0]};
  assign target_zext = {{(XLEN-27){1'b0}}, head_inst[26:0]};

  always_comb begin
    itype = IT_ILL;
    aluop = 5'd0;
    case (head_inst[31:27])
      5'b00000: begin
        itype = IT_R;
        aluop = head_inst[6:2];
      end
      5'b00101, 5'b00111, 5'b01000: itype = IT_I;
      5'b00010, 5'b00110: begin
        itype = IT_I;
        aluop = 5'b00001;
      end
      5'b00001, 5'b00011, 5'b10110, 5'b10101: itype = IT_JI;
      5'b00100: itype = IT_JII;
      default:  itype = IT_ILL;
    endcase
    // Empty queue reports a benign R-type so stale storage never looks illegal.
    if (!out_valid) begin
      itype = IT_R;
      aluop = 5'd0;
    end
    illegal = (itype == IT_ILL);
  end

endmodule

// File: tb/tb_inst_decode_stage.sv
// tb/tb_inst_decode_stage.sv - self-checking bench for inst_decode_stage
module tb_inst_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = '0;
  logic [31:0] pc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_sext, target_zext;
  logic [2:0]  itype;
  logic        illegal;
  logic [2:0]  count;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] inst64 = '0;
  logic [63:0] pc_in64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b0;
  logic [63:0] pc_out64;
  logic [4:0]  opcode64, rd64, rs64, rt64, shamt64, aluop64;
  logic [63:0] imm_sext64, target_zext64;
  logic [2:0]  itype64;
  logic        illegal64;
  logic [3:0]  count64;

  always #5 clock = ~clock;

  inst_decode_stage #(.XLEN(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .aluop(aluop),
    .imm_sext(imm_sext), .target_zext(target_zext), .itype(itype),
    .illegal(illegal), .count(count)
  );

  inst_decode_stage #(.XLEN(64), .DEPTH(8)) dut64 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .inst(inst64), .pc_in(pc_in64),
    .out_valid(out_valid64), .out_ready(out_ready64), .pc_out(pc_out64),
    .opcode(opcode64), .rd(rd64), .rs(rs64), .rt(rt64), .shamt(shamt64),
    .aluop(aluop64), .imm_sext(imm_sext64), .target_zext(target_zext64),
    .itype(itype64), .illegal(illegal64), .count(count64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  op, rd, rs, rt, sh, alu;
    logic [2:0]  it;
    logic [31:0] imm, tgt;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  ent_t q [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc [4];
    logic        exp_rdy;
    logic [31:0] pc_ctr;
    ent_t        e;

    vecs[0]  = '{32'h28C3FFFB, 32'h40, 5'd5,  5'd3,  5'd1, 5'd31, 5'd31, 5'd0, 3'd1, 32'hFFFFFFFB, 32'h00C3FFFB};
    vecs[1]  = '{32'h01444000, 32'h44, 5'd0,  5'd5,  5'd2, 5'd4,  5'd0,  5'd0, 3'd0, 32'h00004000, 32'h01444000};
    vecs[2]  = '{32'h0144410C, 32'h48, 5'd0,  5'd5,  5'd2, 5'd4,  5'd2,  5'd3, 3'd0, 32'h0000410C, 32'h0144410C};
    vecs[3]  = '{32'h18000123, 32'h4C, 5'd3,  5'd0,  5'd0, 5'd0,  5'd2,  5'd0, 3'd2, 32'h00000123, 32'h00000123};
    vecs[4]  = '{32'h27C00000, 32'h50, 5'd4,  5'd31, 5'd0, 5'd0,  5'd0,  5'd0, 3'd3, 32'h00000000, 32'h07C00000};
    vecs[5]  = '{32'hF8000000, 32'h54, 5'd31, 5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd4, 32'h00000000, 32'h00000000};
    vecs[6]  = '{32'h10010000, 32'h58, 5'd2,  5'd0,  5'd0, 5'd16, 5'd0,  5'd1, 3'd1, 32'hFFFF0000, 32'h00010000};
    vecs[7]  = '{32'h3000007C, 32'h5C, 5'd6,  5'd0,  5'd0, 5'd0,  5'd0,  5'd1, 3'd1, 32'h0000007C, 32'h0000007C};
    vecs[8]  = '{32'h4000007C, 32'h60, 5'd8,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd1, 32'h0000007C, 32'h0000007C};
    vecs[9]  = '{32'h3800007C, 32'h64, 5'd7,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd1, 32'h0000007C, 32'h0000007C};
    vecs[10] = '{32'hA8000000, 32'h68, 5'd21, 5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd2, 32'h00000000, 32'h00000000};
    vecs[11] = '{32'hB0000000, 32'h6C, 5'd22, 5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd2, 32'h00000000, 32'h00000000};
    vecs[12] = '{32'h08000000, 32'h70, 5'd1,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd2, 32'h00000000, 32'h00000000};
    vecs[13] = '{32'h48000000, 32'h74, 5'd9,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd4, 32'h00000000, 32'h00000000};
    vecs[14] = '{32'h2800007C, 32'h78, 5'd5,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0, 3'd1, 32'h0000007C, 32'h0000007C};

    tick();
    tick();
    reset = 1'b0;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.count", count, 0);
    chk("rst.itype", itype, 0);
    chk("rst.illegal", illegal, 0);
    chk("rst.aluop", aluop, 0);

    for (int i = 0; i < NV; i++) begin
      inst = vecs[i].inst;
      pc_in = vecs[i].pc;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d.out_valid", i), out_valid, 1);
      chk($sformatf("v%0d.count", i), count, 1);
      chk($sformatf("v%0d.pc_out", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d.opcode", i), opcode, vecs[i].op);
      chk($sformatf("v%0d.rd", i), rd, vecs[i].rd);
      chk($sformatf("v%0d.rs", i), rs, vecs[i].rs);
      chk($sformatf("v%0d.rt", i), rt, vecs[i].rt);
      chk($sformatf("v%0d.shamt", i), shamt, vecs[i].sh);
      chk($sformatf("v%0d.aluop", i), aluop, vecs[i].alu);
      chk($sformatf("v%0d.itype", i), itype, vecs[i].it);
      chk($sformatf("v%0d.illegal", i), illegal, vecs[i].it == 3'd4);
      chk($sformatf("v%0d.imm_sext", i), imm_sext, vecs[i].imm);
      chk($sformatf("v%0d.target_zext", i), target_zext, vecs[i].tgt);
      tick();
      chk($sformatf("v%0d.drained", i), out_valid, 0);
    end

    // Fill to DEPTH, ignored push while full, then simultaneous push/pop.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inst = 32'(k);
      pc_in = 32'h100 + 32'(4 * k);
      in_valid = 1'b1;
      tick();
    end
    chk("full.count", count, 4);
    chk("full.in_ready", in_ready, 0);
    inst = 32'hF8000000;
    pc_in = 32'h1FC;
    tick();
    chk("full.ignored_count", count, 4);
    chk("full.head", pc_out, 32'h100);
    pc_in = 32'h110;
    out_ready = 1'b1;
    #1;
    chk("full.in_ready_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("full.pushpop_count", count, 4);
    exp_pc = '{32'h104, 32'h108, 32'h10C, 32'h110};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d.pc_out", k), pc_out, exp_pc[k]);
      tick();
    end
    chk("drain.empty", out_valid, 0);
    chk("drain.count", count, 0);

    // Flush with count=3 and a concurrent push.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inst = 32'hF8000000;
      pc_in = 32'h200 + 32'(4 * k);
      in_valid = 1'b1;
      tick();
    end
    chk("flush.pre_count", count, 3);
    flush = 1'b1;
    pc_in = 32'h2FC;
    #1;
    chk("flush.in_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.count", count, 0);
    chk("flush.out_valid", out_valid, 0);
    tick();
    chk("flush.no_push", out_valid, 0);
    inst = 32'h01444000;
    pc_in = 32'h300;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flush.after_pc", pc_out, 32'h300);
    chk("flush.after_count", count, 1);
    tick();

    // Reset mid-stream with illegal entries queued.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inst = 32'hF8000000;
      pc_in = 32'h400 + 32'(4 * k);
      in_valid = 1'b1;
      tick();
    end
    chk("mreset.pre_illegal", illegal, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("mreset.count", count, 0);
    chk("mreset.out_valid", out_valid, 0);
    chk("mreset.itype", itype, 0);
    chk("mreset.illegal", illegal, 0);
    chk("mreset.aluop", aluop, 0);
    chk("mreset.in_ready", in_ready, 1);

    // Randomised traffic against a reference queue.
    pc_ctr = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd.count", count, q.size());
      chk("rnd.out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd.pc_out", pc_out, q[0].pc);
        chk("rnd.opcode", opcode, q[0].inst[31:27]);
        chk("rnd.imm_sext", imm_sext, {{15{q[0].inst[16]}}, q[0].inst[16:0]});
      end
      in_valid = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      flush = ($urandom_range(0, 99) < 3);
      inst = $urandom;
      pc_in = pc_ctr;
      #1;
      exp_rdy = (q.size() < 4) || out_ready;
      chk("rnd.in_ready", in_ready, exp_rdy);
      if (flush) begin
        q.delete();
      end else begin
        if (out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          e.inst = inst;
          e.pc = pc_ctr;
          q.push_back(e);
          pc_ctr = pc_ctr + 32'd4;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;

    // Wide-datapath, deeper instance.
    for (int k = 0; k < 8; k++) begin
      inst64 = 32'h0001FFFB | (32'(k) << 22);
      pc_in64 = 64'h1_0000_0000 + 64'(8 * k);
      in_valid64 = 1'b1;
      tick();
    end
    in_valid64 = 1'b0;
    chk("x64.count", count64, 8);
    chk("x64.in_ready", in_ready64, 0);
    out_ready64 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("x64_%0d.pc_out", k), pc_out64, 64'h1_0000_0000 + 64'(8 * k));
      chk($sformatf("x64_%0d.rd", k), rd64, k);
      chk($sformatf("x64_%0d.imm_sext", k), imm_sext64, 64'hFFFFFFFFFFFFFFFB);
      chk($sformatf("x64_%0d.target_zext", k), target_zext64, 64'h1FFFB | (64'(k) << 22));
      tick();
    end
    chk("x64.empty", out_valid64, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
